// File: rtl/irq_controller_n.sv
// Banked interrupt aggregator: NUM_IRQ active-low requests -> registered irqb_master, with vector and EOI.
// Optional macro IRQ_CTRL_SYNC_EN inserts a 2-flop synchroniser on every irqb_in bit.
module irq_controller_n #(
   parameter int NUM_IRQ = 16
) (
   input  logic               clk,
   input  logic               resetb,
   input  logic               cs,
   input  logic               rwb,
   input  logic [2:0]         addr,
   input  logic [7:0]         i_data,
   output logic [7:0]         o_data,
   input  logic [NUM_IRQ-1:0] irqb_in,
   output logic               irqb_master
);

   localparam int NUM_BANKS = (NUM_IRQ + 7) / 8;

   localparam logic [2:0] A_VECTOR  = 3'd0;
   localparam logic [2:0] A_BANK    = 3'd1;
   localparam logic [2:0] A_ENABLE  = 3'd2;
   localparam logic [2:0] A_PENDING = 3'd3;
   localparam logic [2:0] A_MODE    = 3'd4;
   localparam logic [2:0] A_RAW     = 3'd5;
   localparam logic [2:0] A_EOI     = 3'd6;

   logic [NUM_IRQ-1:0] irq_s;
   logic [NUM_IRQ-1:0] raw;
   logic [NUM_IRQ-1:0] prev_sample;
   logic [NUM_IRQ-1:0] enable;
   logic [NUM_IRQ-1:0] mode;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] pending_nxt;
   logic [NUM_IRQ-1:0] active;
   logic [NUM_IRQ-1:0] fall;
   logic [NUM_IRQ-1:0] sel;
   logic [NUM_IRQ-1:0] wdata;
   logic [NUM_IRQ-1:0] eoi_hit;
   logic [NUM_IRQ-1:0] clr;
   logic [2:0]         bank;
   logic [5:0]         bank_base;
   logic [5:0]         vec_idx;
   logic               bank_ok;
   logic               wr_en;
   logic [63:0]        en_pad;
   logic [63:0]        mode_pad;
   logic [63:0]        pend_pad;
   logic [63:0]        raw_pad;

`ifdef IRQ_CTRL_SYNC_EN
   logic [NUM_IRQ-1:0] sync_1;
   logic [NUM_IRQ-1:0] sync_2;

   always_ff @(posedge clk) begin
      if (!resetb) begin
         sync_1 <= '1;
         sync_2 <= '1;
      end else begin
         sync_1 <= irqb_in;
         sync_2 <= sync_1;
      end
   end

   assign irq_s = sync_2;
`else
   assign irq_s = irqb_in;
`endif

   assign wr_en     = cs & ~rwb;
   assign bank_ok   = int'({29'd0, bank}) < NUM_BANKS;
   assign bank_base = {bank, 3'b000};
   assign raw       = ~irq_s;

   always_comb begin
      sel     = '0;
      wdata   = '0;
      eoi_hit = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         sel[i]     = bank_ok && ((i / 8) == int'({29'd0, bank}));
         wdata[i]   = i_data[i % 8];
         eoi_hit[i] = wr_en && (addr == A_EOI) && (int'({26'd0, i_data[5:0]}) == i);
      end
   end

   // Clears only matter for edge channels; a fresh edge in the same cycle wins over a clear.
   assign clr         = ({NUM_IRQ{wr_en && (addr == A_PENDING)}} & sel & wdata) | eoi_hit;
   assign fall        = prev_sample & ~irq_s;
   assign pending_nxt = (mode & (fall | (pending & ~clr))) | (~mode & raw);
   assign active      = pending & enable;

   always_ff @(posedge clk) begin
      if (!resetb) begin
         enable      <= '0;
         mode        <= '0;
         pending     <= '0;
         bank        <= '0;
         prev_sample <= '1;
         irqb_master <= 1'b1;
      end else begin
         prev_sample <= irq_s;
         pending     <= pending_nxt;
         irqb_master <= ~|active;
         if (wr_en && (addr == A_BANK))
            bank <= i_data[2:0];
         if (wr_en && (addr == A_ENABLE))
            enable <= (enable & ~sel) | (wdata & sel);
         if (wr_en && (addr == A_MODE))
            mode <= (mode & ~sel) | (wdata & sel);
      end
   end

   always_comb begin
      vec_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (active[i])
            vec_idx = 6'(i);
   end

   // Zero-padded to 64 so any bank slice stays in range; unused channels read 0.
   assign en_pad   = 64'(enable);
   assign mode_pad = 64'(mode);
   assign pend_pad = 64'(pending);
   assign raw_pad  = 64'(raw);

   always_comb begin
      o_data = 8'h00;
      case (addr)
         A_VECTOR:  o_data = (|active) ? {2'b00, vec_idx} : 8'h80;
         A_BANK:    o_data = {5'd0, bank};
         A_ENABLE:  if (bank_ok) o_data = en_pad[bank_base +: 8];
         A_PENDING: if (bank_ok) o_data = pend_pad[bank_base +: 8];
         A_MODE:    if (bank_ok) o_data = mode_pad[bank_base +: 8];
         A_RAW:     if (bank_ok) o_data = raw_pad[bank_base +: 8];
         default:   o_data = 8'h00;
      endcase
   end

endmodule
